// File: rtl/mem_pkg.sv
// Shared constants for the memory responder.
// Request bit positions and range helper.
package mem_pkg;

  localparam int DEPTH_LOG2_DEF = 12;

  localparam int REQ_W  = 2;
  localparam int REQ_DR = 1;
  localparam int REQ_IR = 0;

  typedef logic [2:0] req_t;

  // Offset is in range when below 4 bytes * 2^dl2 words.
  function automatic logic in_range(
    input logic [31:0] off,
    input int unsigned dl2
  );
    return {1'b0, off} < (33'd4 << dl2);
  endfunction

endpackage

// File: rtl/mem_ram.sv
// Single-port synchronous RAM, 32-bit words,
// byte enables, one-cycle read latency.
module mem_ram #(
  parameter int AW = 12
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  // Byte-masked write, or registered read.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Three-channel memory responder: one grant per
// cycle, write > data read > inst read.
module mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INST_RDEN,
  input  logic [31:0] INST_RIADDR,
  output logic [31:0] INST_ROADDR,
  output logic        INST_RVALID,
  output logic [31:0] INST_RDATA,
  input  logic        DATA_RDEN,
  input  logic [31:0] DATA_RIADDR,
  output logic [31:0] DATA_ROADDR,
  output logic        DATA_RVALID,
  output logic [31:0] DATA_RDATA,
  input  logic        DATA_WREN,
  input  logic [3:0]  DATA_WSTRB,
  input  logic [31:0] DATA_WADDR,
  input  logic [31:0] DATA_WDATA,
  output logic        MEM_WAIT
);

  localparam int unsigned DL2 = DEPTH_LOG2;

  req_t served_q, served_d;
  req_t pend, grant;

  logic [31:0] w_off, d_off, i_off;
  logic        w_inr, d_inr, i_inr;
  logic        wait_c;

  logic [DEPTH_LOG2-1:0] ram_addr;
  logic        ram_en, ram_we;
  logic [31:0] ram_rdata;

  logic        irv_q, drv_q;
  logic        iinr_q, dinr_q;
  logic [31:0] ia_q, da_q;
  logic [31:0] idh_q, ddh_q;
  logic [31:0] i_now, d_now;

  assign w_off = DATA_WADDR  - BASE_ADDR;
  assign d_off = DATA_RIADDR - BASE_ADDR;
  assign i_off = INST_RIADDR - BASE_ADDR;
  assign w_inr = in_range(w_off, DL2);
  assign d_inr = in_range(d_off, DL2);
  assign i_inr = in_range(i_off, DL2);

  assign pend = {DATA_WREN, DATA_RDEN, INST_RDEN} & ~served_q;

  // Fixed-priority grant and RAM port steering.
  always_comb begin
    grant    = '0;
    ram_addr = '0;
    priority case (1'b1)
      pend[REQ_W]: begin
        grant[REQ_W] = 1'b1;
        ram_addr     = w_off[DEPTH_LOG2+1:2];
      end
      pend[REQ_DR]: begin
        grant[REQ_DR] = 1'b1;
        ram_addr      = d_off[DEPTH_LOG2+1:2];
      end
      pend[REQ_IR]: begin
        grant[REQ_IR] = 1'b1;
        ram_addr      = i_off[DEPTH_LOG2+1:2];
      end
      default: ;
    endcase
  end

  assign wait_c   = ~RST & (|(pend & ~grant));
  assign served_d = wait_c ? (served_q | grant) : '0;
  assign MEM_WAIT = wait_c;

  // Out-of-range writes never touch the array.
  assign ram_we = grant[REQ_W] & w_inr;
  assign ram_en = ~RST & (grant[REQ_W] ? w_inr : |grant);

  mem_ram #(
    .AW(DEPTH_LOG2)
  ) u_ram (
    .clk_i  (CLK),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .be_i   (DATA_WSTRB),
    .addr_i (ram_addr),
    .wdata_i(DATA_WDATA),
    .rdata_o(ram_rdata)
  );

  assign i_now = iinr_q ? ram_rdata : 32'h0;
  assign d_now = dinr_q ? ram_rdata : 32'h0;

  // Served mask, response strobes and held read data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      served_q <= '0;
      irv_q    <= 1'b0;
      drv_q    <= 1'b0;
      iinr_q   <= 1'b0;
      dinr_q   <= 1'b0;
      ia_q     <= 32'h0;
      da_q     <= 32'h0;
      idh_q    <= 32'h0;
      ddh_q    <= 32'h0;
    end else begin
      served_q <= served_d;
      irv_q    <= grant[REQ_IR];
      drv_q    <= grant[REQ_DR];
      if (grant[REQ_IR]) begin
        ia_q   <= INST_RIADDR;
        iinr_q <= i_inr;
      end
      if (grant[REQ_DR]) begin
        da_q   <= DATA_RIADDR;
        dinr_q <= d_inr;
      end
      if (irv_q) idh_q <= i_now;
      if (drv_q) ddh_q <= d_now;
    end
  end

  assign INST_RVALID = irv_q & ~RST;
  assign DATA_RVALID = drv_q & ~RST;
  assign INST_ROADDR = RST ? 32'h0 : ia_q;
  assign DATA_ROADDR = RST ? 32'h0 : da_q;
  assign INST_RDATA  = RST ? 32'h0 : (irv_q ? i_now : idh_q);
  assign DATA_RDATA  = RST ? 32'h0 : (drv_q ? d_now : ddh_q);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a
// transaction-level schedule model.
module tb_mem_responder;

  localparam int          DL2  = 4;
  localparam int          NW   = 16;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        INST_RDEN = 1'b0;
  logic [31:0] INST_RIADDR = '0;
  logic [31:0] INST_ROADDR;
  logic        INST_RVALID;
  logic [31:0] INST_RDATA;
  logic        DATA_RDEN = 1'b0;
  logic [31:0] DATA_RIADDR = '0;
  logic [31:0] DATA_ROADDR;
  logic        DATA_RVALID;
  logic [31:0] DATA_RDATA;
  logic        DATA_WREN = 1'b0;
  logic [3:0]  DATA_WSTRB = '0;
  logic [31:0] DATA_WADDR = '0;
  logic [31:0] DATA_WDATA = '0;
  logic        MEM_WAIT;

  mem_responder #(
    .DEPTH_LOG2(DL2),
    .BASE_ADDR (BASE)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .INST_RDEN  (INST_RDEN),
    .INST_RIADDR(INST_RIADDR),
    .INST_ROADDR(INST_ROADDR),
    .INST_RVALID(INST_RVALID),
    .INST_RDATA (INST_RDATA),
    .DATA_RDEN  (DATA_RDEN),
    .DATA_RIADDR(DATA_RIADDR),
    .DATA_ROADDR(DATA_ROADDR),
    .DATA_RVALID(DATA_RVALID),
    .DATA_RDATA (DATA_RDATA),
    .DATA_WREN  (DATA_WREN),
    .DATA_WSTRB (DATA_WSTRB),
    .DATA_WADDR (DATA_WADDR),
    .DATA_WDATA (DATA_WDATA),
    .MEM_WAIT   (MEM_WAIT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Model memory and per-cycle expectation schedule.
  logic [31:0] mm [NW];
  bit          ew  [int];
  logic [31:0] eia [int];
  logic [31:0] eid [int];
  logic [31:0] eda [int];
  logic [31:0] edd [int];

  logic [31:0] li_a = '0, li_d = '0;
  logic [31:0] ld_a = '0, ld_d = '0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, got, exp);
    end
  endtask

  function automatic bit inr(input logic [31:0] a);
    return (a - BASE) < 32'(4 * NW);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(((a - BASE) >> 2) % NW);
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    return inr(a) ? mm[widx(a)] : 32'h0;
  endfunction

  task automatic mwrite(input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0]  s);
    if (inr(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mm[widx(a)][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // Every cycle: compare outputs with the schedule.
  always @(negedge CLK) begin
    if (RST) begin
      chk("rst_wait", 32'(MEM_WAIT), 0);
      chk("rst_irv", 32'(INST_RVALID), 0);
      chk("rst_drv", 32'(DATA_RVALID), 0);
      chk("rst_ia", INST_ROADDR, 0);
      chk("rst_id", INST_RDATA, 0);
      chk("rst_da", DATA_ROADDR, 0);
      chk("rst_dd", DATA_RDATA, 0);
      li_a = '0; li_d = '0;
      ld_a = '0; ld_d = '0;
    end else begin
      chk("wait", 32'(MEM_WAIT), 32'(ew.exists(cyc)));
      if (eia.exists(cyc)) begin
        li_a = eia[cyc]; li_d = eid[cyc];
      end
      if (eda.exists(cyc)) begin
        ld_a = eda[cyc]; ld_d = edd[cyc];
      end
      chk("irv", 32'(INST_RVALID), 32'(eia.exists(cyc)));
      chk("drv", 32'(DATA_RVALID), 32'(eda.exists(cyc)));
      chk("iaddr", INST_ROADDR, li_a);
      chk("idata", INST_RDATA, li_d);
      chk("daddr", DATA_ROADDR, ld_a);
      chk("ddata", DATA_RDATA, ld_d);
      chk("excl", 32'(INST_RVALID & DATA_RVALID), 0);
    end
  end

  // Present one request group, hold it until all
  // members are served, and schedule the outcome.
  task automatic issue(input bit w, input bit dr, input bit ir,
                       input logic [31:0] wa,
                       input logic [31:0] wd,
                       input logic [3:0]  ws,
                       input logic [31:0] dra,
                       input logic [31:0] ira);
    int c0, j, k;
    c0 = cyc;
    j  = 0;
    k  = int'(w) + int'(dr) + int'(ir);
    DATA_WREN = w;  DATA_WADDR = wa;
    DATA_WDATA = wd; DATA_WSTRB = ws;
    DATA_RDEN = dr; DATA_RIADDR = dra;
    INST_RDEN = ir; INST_RIADDR = ira;
    if (w) begin
      if (j < k - 1) ew[c0 + j] = 1'b1;
      mwrite(wa, wd, ws);
      j++;
    end
    if (dr) begin
      if (j < k - 1) ew[c0 + j] = 1'b1;
      eda[c0 + j + 1] = dra;
      edd[c0 + j + 1] = mread(dra);
      j++;
    end
    if (ir) begin
      if (j < k - 1) ew[c0 + j] = 1'b1;
      eia[c0 + j + 1] = ira;
      eid[c0 + j + 1] = mread(ira);
      j++;
    end
    repeat (k) @(posedge CLK);
    #1;
    DATA_WREN = 1'b0;
    DATA_RDEN = 1'b0;
    INST_RDEN = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    issue(1, 0, 0, a, d, s, 0, 0);
  endtask

  task automatic rd_d(input logic [31:0] a);
    issue(0, 1, 0, 0, 0, 0, a, 0);
  endtask

  task automatic rd_i(input logic [31:0] a);
    issue(0, 0, 1, 0, 0, 0, 0, a);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    idle(3);
    RST = 1'b0;

    // Lone instruction read, zero added latency.
    wr(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
    rd_i(BASE + 32'h10);
    @(negedge CLK);
    chk("lit_irv", 32'(INST_RVALID), 1);
    chk("lit_iaddr", INST_ROADDR, 32'h0000_1010);
    chk("lit_idata", INST_RDATA, 32'hDEAD_BEEF);
    chk("lit_wait", 32'(MEM_WAIT), 0);
    #1;
    @(posedge CLK); #1;

    // Byte-strobed write then data read.
    wr(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF);
    wr(BASE + 32'h20, 32'h1122_3344, 4'b0101);
    rd_d(BASE + 32'h20);
    @(negedge CLK);
    chk("lit_strb", DATA_RDATA, 32'hFF22_FF44);
    #1;
    @(posedge CLK); #1;

    // Low address bits ignored for lookup, echoed back.
    rd_d(BASE + 32'h13);
    @(negedge CLK);
    chk("lit_lowbits_a", DATA_ROADDR, 32'h0000_1013);
    chk("lit_lowbits_d", DATA_RDATA, 32'hDEAD_BEEF);
    #1;
    @(posedge CLK); #1;

    // Fill every word back-to-back, then read back.
    for (int i = 0; i < NW; i++)
      wr(BASE + 32'(4 * i), 32'h0101_0101 * i ^ 32'hA5C3_0F00,
         4'hF);
    for (int i = 0; i < NW; i++) begin
      if (i % 2 == 0) rd_d(BASE + 32'(4 * i));
      else            rd_i(BASE + 32'(4 * i));
    end
    idle(2);

    // All three requests at once.
    issue(1, 1, 1, BASE + 32'h30, 32'hCAFE_F00D, 4'hF,
          BASE + 32'h30, BASE + 32'h4);
    @(negedge CLK);
    chk("lit_3req_irv", 32'(INST_RVALID), 1);
    chk("lit_3req_dhold", DATA_RDATA, 32'hCAFE_F00D);
    #1;
    idle(1);

    // Pairs of requests.
    issue(0, 1, 1, 0, 0, 0, BASE + 32'h8, BASE + 32'hC);
    issue(1, 0, 1, BASE + 32'h14, 32'h0BAD_CAFE, 4'b1000,
          0, BASE + 32'h14);
    issue(1, 1, 0, BASE + 32'h18, 32'h7777_0000, 4'b0011,
          BASE + 32'h18, 0);
    idle(2);

    // Out-of-range reads and writes.
    wr(BASE + 32'h40, 32'h1234_5678, 4'hF);
    wr(BASE - 32'h4, 32'h8765_4321, 4'hF);
    rd_d(BASE + 32'h40);
    @(negedge CLK);
    chk("lit_oor_drv", 32'(DATA_RVALID), 1);
    chk("lit_oor_dd", DATA_RDATA, 32'h0);
    #1;
    rd_i(BASE - 32'h4);
    for (int i = 0; i < NW; i++) rd_d(BASE + 32'(4 * i));
    idle(2);

    // Reset in the middle of a three-request stall.
    begin
      int c0;
      c0 = cyc;
      DATA_WREN = 1'b1; DATA_WADDR = BASE + 32'h8;
      DATA_WDATA = 32'h55AA_55AA; DATA_WSTRB = 4'hF;
      DATA_RDEN = 1'b1; DATA_RIADDR = BASE + 32'h8;
      INST_RDEN = 1'b1; INST_RIADDR = BASE + 32'h0;
      ew[c0] = 1'b1;
      mwrite(BASE + 32'h8, 32'h55AA_55AA, 4'hF);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      DATA_WREN = 1'b0;
      DATA_RDEN = 1'b0;
      INST_RDEN = 1'b0;
      idle(3);
      @(negedge CLK);
      chk("lit_post_rst_wait", 32'(MEM_WAIT), 0);
      chk("lit_post_rst_drv", 32'(DATA_RVALID), 0);
      #1;
      @(posedge CLK); #1;
    end

    // Service resumes with zero latency.
    rd_d(BASE + 32'h8);
    @(negedge CLK);
    chk("lit_after_rst", DATA_RDATA, 32'h55AA_55AA);
    #1;
    rd_i(BASE + 32'h30);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
